apb3_interconnect: RTL and testbench

APB3_INTERCONNECT -- requirements
Module: apb3_interconnect

---
 rtl/apb3_ic_pkg.sv | 16 +
 rtl/apb3_slot_decode.sv | 19 +
 rtl/apb3_interconnect.sv | 165 ++++++++++++++++
 tb/tb_apb3_interconnect.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb3_ic_pkg.sv
// Shared types for the APB3 interconnect: FSM states and slot-index encoding.
package apb3_ic_pkg;

    localparam int SLOT_FIELD_W = 4;

    typedef logic [SLOT_FIELD_W-1:0] slot_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP,
        ERR
    } state_t;

endpackage

// File: rtl/apb3_slot_decode.sv
// Combinational address decoder: extracts the 4-bit slot field and flags whether
// that slot exists and is enabled.
module apb3_slot_decode
    import apb3_ic_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          NUM_SLOTS  = 8,
    parameter int          SLOT_LSB   = 12,
    parameter logic [15:0] SLOT_EN    = 16'hFFFF
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    output slot_idx_t             slot_idx,
    output logic                  mapped
);

    assign slot_idx = paddr[SLOT_LSB +: SLOT_FIELD_W];
    assign mapped   = ({28'd0, slot_idx} < 32'(NUM_SLOTS)) && SLOT_EN[slot_idx];

endmodule

// File: rtl/apb3_interconnect.sv
// APB3 one-master to NUM_SLOTS-slave interconnect with registered slave-side
// phases, unmapped-slot error response and an optional access-phase timeout.
module apb3_interconnect
    import apb3_ic_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          NUM_SLOTS      = 8,
    parameter int          SLOT_LSB       = 12,
    parameter logic [15:0] SLOT_EN        = 16'hFFFF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                             PCLK,
    input  logic                             PRESETN,
    input  logic                             PSEL,
    input  logic                             PENABLE,
    input  logic                             PWRITE,
    input  logic [ADDR_WIDTH-1:0]            PADDR,
    input  logic [DATA_WIDTH-1:0]            PWDATA,
    output logic                             PREADY,
    output logic                             PSLVERR,
    output logic [DATA_WIDTH-1:0]            PRDATA,
    output logic [NUM_SLOTS-1:0]             PSELS,
    output logic                             PENABLES,
    output logic                             PWRITES,
    output logic [ADDR_WIDTH-1:0]            PADDRS,
    output logic [DATA_WIDTH-1:0]            PWDATAS,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0]  PRDATAS,
    input  logic [NUM_SLOTS-1:0]             PREADYS,
    input  logic [NUM_SLOTS-1:0]             PSLVERRS,
    output logic                             TIMEOUT
);

    // A disabled timeout still keeps a 1-bit counter so no zero-width vectors appear.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t                  state_reg,   state_next;
    slot_idx_t               slot_reg,    slot_next;
    logic [ADDR_WIDTH-1:0]   addr_reg,    addr_next;
    logic                    write_reg,   write_next;
    logic [DATA_WIDTH-1:0]   wdata_reg,   wdata_next;
    logic [DATA_WIDTH-1:0]   rdata_reg,   rdata_next;
    logic                    err_reg,     err_next;
    logic                    timeout_reg, timeout_next;
    logic [CNT_W-1:0]        cnt_reg,     cnt_next;

    slot_idx_t               dec_slot;
    logic                    dec_mapped;
    logic [NUM_SLOTS-1:0]    slot_hit;
    logic                    slv_ready;
    logic                    slv_err;
    logic [DATA_WIDTH-1:0]   slv_rdata;
    logic                    in_xfer;

    apb3_slot_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_LSB   (SLOT_LSB),
        .SLOT_EN    (SLOT_EN)
    ) u_decode (
        .paddr    (PADDR),
        .slot_idx (dec_slot),
        .mapped   (dec_mapped)
    );

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_hit
        assign slot_hit[gi] = (slot_reg == slot_idx_t'(gi));
    end

    // AND-OR mux of the selected slave's response signals.
    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slv_ready = slv_ready | (slot_hit[i] & PREADYS[i]);
            slv_err   = slv_err   | (slot_hit[i] & PSLVERRS[i]);
            slv_rdata = slv_rdata | ({DATA_WIDTH{slot_hit[i]}} & PRDATAS[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_reg   <= IDLE;
            slot_reg    <= '0;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            slot_reg    <= slot_next;
            addr_reg    <= addr_next;
            write_reg   <= write_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
            timeout_reg <= timeout_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        slot_next    = slot_reg;
        addr_next    = addr_reg;
        write_next   = write_reg;
        wdata_next   = wdata_reg;
        rdata_next   = rdata_reg;
        err_next     = err_reg;
        timeout_next = 1'b0;
        cnt_next     = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    slot_next  = dec_slot;
                    addr_next  = PADDR;
                    write_next = PWRITE;
                    wdata_next = PWDATA;
                    cnt_next   = '0;
                    state_next = dec_mapped ? SETUP : ERR;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                // A ready slave takes priority over a simultaneous timeout.
                if (slv_ready) begin
                    rdata_next = slv_rdata;
                    err_next   = slv_err;
                    state_next = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST)) begin
                    rdata_next   = '0;
                    err_next     = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_xfer  = (state_reg == SETUP) || (state_reg == ACCESS);
    assign PSELS    = in_xfer ? slot_hit : '0;
    assign PENABLES = (state_reg == ACCESS);
    assign PWRITES  = in_xfer & write_reg;
    assign PADDRS   = in_xfer ? addr_reg  : '0;
    assign PWDATAS  = in_xfer ? wdata_reg : '0;
    assign PREADY   = (state_reg == RESP) || (state_reg == ERR);
    assign PSLVERR  = ((state_reg == RESP) && err_reg) || (state_reg == ERR);
    assign PRDATA   = (state_reg == RESP) ? rdata_reg : '0;
    assign TIMEOUT  = timeout_reg;

endmodule

// File: tb/tb_apb3_interconnect.sv
// Self-checking bench for apb3_interconnect: table of transfers against a
// behavioural slave bank, plus reset-abort and post-reset recovery sequences.
module tb_apb3_interconnect;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 8;

    // Per-slot slave behaviour: wait states (-1 = never ready), data, error.
    localparam int          SLOT_WAIT  [NS] = '{0, -1, 0, 1, 2, 3, 0, 0};
    localparam logic [31:0] SLOT_RDATA [NS] = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF,
                                                32'h3333_0003, 32'h4444_0004, 32'h5555_0005,
                                                32'h6666_0006, 32'h7777_0007};
    localparam logic [NS-1:0] SLOT_ERR = 8'b0000_1000;

    logic              PCLK, PRESETN;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic              PREADY, PSLVERR;
    logic [DW-1:0]     PRDATA;
    logic [NS-1:0]     PSELS;
    logic              PENABLES, PWRITES;
    logic [AW-1:0]     PADDRS;
    logic [DW-1:0]     PWDATAS;
    logic [NS*DW-1:0]  PRDATAS;
    logic [NS-1:0]     PREADYS;
    logic [NS-1:0]     PSLVERRS;
    logic              TIMEOUT;

    apb3_interconnect #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_SLOTS      (NS),
        .SLOT_LSB       (12),
        .SLOT_EN        (16'hFF7F),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .PRDATA   (PRDATA),
        .PSELS    (PSELS),
        .PENABLES (PENABLES),
        .PWRITES  (PWRITES),
        .PADDRS   (PADDRS),
        .PWDATAS  (PWDATAS),
        .PRDATAS  (PRDATAS),
        .PREADYS  (PREADYS),
        .PSLVERRS (PSLVERRS),
        .TIMEOUT  (TIMEOUT)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Slave bank model: ready after SLOT_WAIT[i] extra access cycles.
    int acc_cnt = 0;
    always_ff @(posedge PCLK) begin
        acc_cnt <= (PENABLES && (|PSELS) && !(|PREADYS)) ? acc_cnt + 1 : 0;
    end

    always_comb begin
        PREADYS = '0;
        for (int i = 0; i < NS; i++) begin
            PREADYS[i] = PSELS[i] && PENABLES && (SLOT_WAIT[i] >= 0) && (acc_cnt == SLOT_WAIT[i]);
        end
    end

    for (genvar gi = 0; gi < NS; gi++) begin : g_slv
        assign PRDATAS[gi*DW +: DW] = SLOT_RDATA[gi];
    end
    assign PSLVERRS = SLOT_ERR;

    typedef struct {
        logic          write;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [NS-1:0] exp_sel;
        int            exp_lat;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic          exp_to;
        logic          drop;
    } vec_t;

    vec_t vecs [11];
    vec_t sb_q [$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        vec_t e;
        int   ready_at = 0;
        int   sel_cnt  = 0;
        logic phase_ok = 1'b1;
        sb_q.push_back(v);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = v.write;
        PADDR   = v.addr;
        PWDATA  = v.wdata;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        for (int k = 1; k <= 20 && ready_at == 0; k++) begin
            @(negedge PCLK);
            if (v.drop && k == 2) begin
                PSEL    = 1'b0;
                PENABLE = 1'b0;
            end
            if (PSELS != '0) begin
                sel_cnt++;
                if (PSELS != v.exp_sel || PADDRS != v.addr || PWDATAS != v.wdata ||
                    PWRITES != v.write || PENABLES != (k >= 2))
                    phase_ok = 1'b0;
            end else if (PENABLES) begin
                phase_ok = 1'b0;
            end
            if (PREADY) begin
                ready_at = k;
            end else if (TIMEOUT || PSLVERR || PRDATA != '0) begin
                phase_ok = 1'b0;
            end
        end
        e = sb_q.pop_front();
        $display("vec %0d: addr %h write %b lat %0d rdata %h err %b to %b",
                 id, e.addr, e.write, ready_at, PRDATA, PSLVERR, TIMEOUT);
        chk("latency",   32'(ready_at), 32'(e.exp_lat));
        chk("prdata",    PRDATA,        e.exp_rdata);
        chk("pslverr",   32'(PSLVERR),  32'(e.exp_err));
        chk("timeout",   32'(TIMEOUT),  32'(e.exp_to));
        chk("sel_cycles", 32'(sel_cnt), (e.exp_sel != '0) ? 32'(e.exp_lat - 1) : 32'd0);
        chk("phase_ok",  32'(phase_ok), 32'd1);
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
        chk("pready_one_cycle", 32'(PREADY), 32'd0);
    endtask

    logic [108:0] outs;
    function automatic logic [108:0] all_outs();
        return {PREADY, PSLVERR, PRDATA, PSELS, PENABLES, PWRITES, PADDRS, PWDATAS, TIMEOUT};
    endfunction

    initial begin
        logic seen_ready;
        vec_t rv;
        //             write addr          wdata          sel    lat rdata          err   to    drop
        vecs[0]  = '{1'b0, 32'h0000_2004, 32'h0,         8'h04, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_5010, 32'h1234_5678, 8'h20, 6, 32'h5555_0005, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_A000, 32'h0,         8'h00, 1, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         8'h02, 6, 32'h0,         1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_3008, 32'h0,         8'h08, 4, 32'h3333_0003, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_4FFC, 32'hCAFE_F00D, 8'h10, 5, 32'h4444_0004, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_7000, 32'h0,         8'h00, 1, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         8'h01, 3, 32'h1111_0000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_6ABC, 32'h0F0F_0F0F, 8'h40, 3, 32'h6666_0006, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_F000, 32'h0,         8'h00, 1, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h1234_6000, 32'h0,         8'h40, 3, 32'h6666_0006, 1'b0, 1'b0, 1'b0};

        PRESETN = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        outs = all_outs();
        chk("reset_outs_lo", outs[31:0],   32'd0);
        chk("reset_outs_hi", outs[108:77], 32'd0);
        PRESETN = 1'b1;
        @(negedge PCLK);

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset asserted during ACCESS of a 2-wait slot-4 read aborts it silently.
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'h0000_4000;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("abort_in_access", 32'(PENABLES), 32'd1);
        PRESETN = 1'b0;
        @(negedge PCLK);
        outs = all_outs();
        chk("abort_outs_a", outs[31:0],   32'd0);
        chk("abort_outs_b", outs[63:32],  32'd0);
        chk("abort_outs_c", outs[95:64],  32'd0);
        chk("abort_outs_d", 32'(outs[108:96]), 32'd0);
        PRESETN = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        seen_ready = 1'b0;
        repeat (6) begin
            @(negedge PCLK);
            if (PREADY) seen_ready = 1'b1;
        end
        $display("abort: PREADY seen after reset = %b", seen_ready);
        chk("abort_no_pready", 32'(seen_ready), 32'd0);

        rv = '{1'b0, 32'h0000_0010, 32'h0, 8'h01, 3, 32'h1111_0000, 1'b0, 1'b0, 1'b0};
        run_vec(11, rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
